data_memory_ctrl: RTL and testbench

Parametrised byte-addressable data memory for the CPU MEM stage. It replaces the fixed 32-byte, combinational-read, word-only memory. Adds byte/half/word access with sign or zero extension, a configurable access latency behind a req/ready/valid handshake, and alignment/range error reporting. The pipeline stalls on ready_o and valid_o.

---
 rtl/data_memory_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_ctrl
// Purpose  : Byte-addressable data memory for the CPU MEM stage. Supports
//            byte/half/word accesses with sign or zero extension on reads,
//            a configurable access latency behind a req/ready/valid
//            handshake, and alignment, range and size error reporting.
// Ports    : clk_i       - clock, rising edge
//            rst_i       - asynchronous reset, active high
//            req_i       - request, accepted when req_i & ready_o at an edge
//            we_i        - 1 = write, 0 = read
//            size_i      - 0 byte, 1 half, 2 word, 3 reserved (error)
//            unsigned_i  - 1 = zero-extend reads, 0 = sign-extend
//            addr_i      - byte address
//            wdata_i     - write data, low-order bytes used for byte/half
//            ready_o     - block can accept a request this cycle
//            valid_o     - one-cycle response pulse
//            rdata_o     - read result, held until next successful read
//            err_o       - qualifies valid_o: access was rejected
//            rd_count_o / wr_count_o / err_count_o
//                        - response counters (only with DMEM_STATS_EN)
// Options  : `define DMEM_STATS_EN adds the three response counters.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_ctrl #(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]       rd_count_o,
  output logic [31:0]       wr_count_o,
  output logic [31:0]       err_count_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;

  // Request fields captured at acceptance; the requester may change its
  // inputs freely while the access is in flight.
  logic              lat_we;
  logic [1:0]        lat_size;
  logic              lat_uns;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic              accept;
  logic              respond;
  logic              align_err;
  logic              range_err;
  logic              access_err;

  logic [7:0]        mem [DEPTH_BYTES];

  logic [IDX_W-1:0]  idx0;
  logic [IDX_W-1:0]  idx1;
  logic [IDX_W-1:0]  idx2;
  logic [IDX_W-1:0]  idx3;
  logic [7:0]        byte0;
  logic [7:0]        byte1;
  logic [7:0]        byte2;
  logic [7:0]        byte3;
  logic [31:0]       read_data;

  // --------------------------------------------------------------------------
  // FSM next-state and handshake
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    respond    = 1'b0;
    ready_o    = 1'b0;
    case (state)
      IDLE: begin
        // ready is suppressed while reset is held so nothing can be issued
        ready_o = ~rst_i;
        accept  = req_i & ~rst_i;
        if (accept) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          respond    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Error classification on the captured request
  // --------------------------------------------------------------------------
  always_comb begin
    align_err = 1'b0;
    case (lat_size)
      2'd0:    align_err = 1'b0;
      2'd1:    align_err = lat_addr[0];
      2'd2:    align_err = |lat_addr[1:0];
      default: align_err = 1'b1;
    endcase
  end

  generate
    if (ADDR_W > IDX_W) begin : g_range_chk
      assign range_err = |lat_addr[ADDR_W-1:IDX_W];
    end else begin : g_range_none
      assign range_err = 1'b0;
    end
  endgenerate

  assign access_err = align_err | range_err;

  // --------------------------------------------------------------------------
  // Little-endian byte lanes and read extension
  // --------------------------------------------------------------------------
  assign idx0  = lat_addr[IDX_W-1:0];
  assign idx1  = idx0 + IDX_W'(1);
  assign idx2  = idx0 + IDX_W'(2);
  assign idx3  = idx0 + IDX_W'(3);
  assign byte0 = mem[idx0];
  assign byte1 = mem[idx1];
  assign byte2 = mem[idx2];
  assign byte3 = mem[idx3];

  always_comb begin
    read_data = '0;
    case (lat_size)
      2'd0:    read_data = lat_uns ? {24'h0, byte0}
                                   : {{24{byte0[7]}}, byte0};
      2'd1:    read_data = lat_uns ? {16'h0, byte1, byte0}
                                   : {{16{byte1[7]}}, byte1, byte0};
      default: read_data = {byte3, byte2, byte1, byte0};
    endcase
  end

  // --------------------------------------------------------------------------
  // State, counter, captured fields and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      valid_o   <= 1'b0;
      err_o     <= 1'b0;
      rdata_o   <= '0;
      lat_we    <= 1'b0;
      lat_size  <= '0;
      lat_uns   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state   <= state_next;
      valid_o <= respond;
      err_o   <= respond & access_err;
      if (accept) begin
        lat_we    <= we_i;
        lat_size  <= size_i;
        lat_uns   <= unsigned_i;
        lat_addr  <= addr_i;
        lat_wdata <= wdata_i;
        cnt       <= CNT_LOAD;
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (respond && !access_err && !lat_we) begin
        rdata_o <= read_data;
      end
    end
  end

  // Storage is deliberately not reset. An access aborted by reset never
  // reaches this block because reset forces the FSM back to IDLE.
  always_ff @(posedge clk_i) begin
    if (respond && lat_we && !access_err) begin
      mem[idx0] <= lat_wdata[7:0];
      if (lat_size != 2'd0) begin
        mem[idx1] <= lat_wdata[15:8];
      end
      if (lat_size == 2'd2) begin
        mem[idx2] <= lat_wdata[23:16];
        mem[idx3] <= lat_wdata[31:24];
      end
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_count_o  <= '0;
      wr_count_o  <= '0;
      err_count_o <= '0;
    end else if (respond) begin
      if (access_err) begin
        err_count_o <= err_count_o + 32'd1;
      end else if (lat_we) begin
        wr_count_o <= wr_count_o + 32'd1;
      end else begin
        rd_count_o <= rd_count_o + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_ctrl
// Purpose  : Self-checking bench for data_memory_ctrl. Two instances
//            (LATENCY 1 and LATENCY 4) share the request fields and each has
//            its own req line. A byte-array reference model supplies every
//            expected response, including held read data and counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_ctrl;

  localparam int DEPTH = 64;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req1;
  logic          req4;
  logic          we;
  logic [1:0]    size;
  logic          uns;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;

  logic          ready1, valid1, err1;
  logic          ready4, valid4, err4;
  logic [31:0]   rdata1, rdata4;

`ifdef DMEM_STATS_EN
  logic [31:0]   rdc1, wrc1, erc1, rdc4, wrc4, erc4;
`endif

  always #5 clk = ~clk;

  data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .ADDR_W(AW), .LATENCY(1)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we), .size_i(size),
    .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
    .ready_o(ready1), .valid_o(valid1), .rdata_o(rdata1), .err_o(err1)
`ifdef DMEM_STATS_EN
    , .rd_count_o(rdc1), .wr_count_o(wrc1), .err_count_o(erc1)
`endif
  );

  data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .ADDR_W(AW), .LATENCY(4)) u_dut_l4 (
    .clk_i(clk), .rst_i(rst), .req_i(req4), .we_i(we), .size_i(size),
    .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
    .ready_o(ready4), .valid_o(valid4), .rdata_o(rdata4), .err_o(err4)
`ifdef DMEM_STATS_EN
    , .rd_count_o(rdc4), .wr_count_o(wrc4), .err_count_o(erc4)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem_m [DEPTH];
  logic [31:0] exp_rd1;
  logic [31:0] exp_rd4;
  int unsigned cnt1 [3];   // successful reads, successful writes, errors
  int unsigned cnt4 [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: applies the access to the byte array and returns the
  // outcome. Reads assemble little-endian bytes then extend.
  task automatic model(input logic w, input logic [1:0] s, input logic u,
                       input logic [AW-1:0] a, input logic [31:0] d,
                       output logic e, output logic [31:0] r, output int kind);
    int nb;
    e = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) ||
        (int'(a) >= DEPTH);
    r = 32'h0;
    kind = e ? 2 : (w ? 1 : 0);
    if (!e) begin
      nb = 1 << s;
      for (int i = 0; i < nb; i++) begin
        if (w) mem_m[int'(a) + i] = d[8*i +: 8];
        else   r[8*i +: 8] = mem_m[int'(a) + i];
      end
      if (!w && !u && nb < 4 && r[8*nb-1]) begin
        for (int i = nb; i < 4; i++) r[8*i +: 8] = 8'hFF;
      end
    end
  endtask

  task automatic stats_check(input string tag);
`ifdef DMEM_STATS_EN
    check({tag, "_rd1"},  rdc1, cnt1[0]);
    check({tag, "_wr1"},  wrc1, cnt1[1]);
    check({tag, "_er1"},  erc1, cnt1[2]);
    check({tag, "_rd4"},  rdc4, cnt4[0]);
    check({tag, "_wr4"},  wrc4, cnt4[1]);
    check({tag, "_er4"},  erc4, cnt4[2]);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic drive(input logic w, input logic [1:0] s, input logic u,
                       input logic [AW-1:0] a, input logic [31:0] d);
    we = w; size = s; uns = u; addr = a; wdata = d;
  endtask

  // Issues one access to both instances at the same edge and checks every
  // cycle until the slower instance has responded.
  task automatic access(input logic w, input logic [1:0] s, input logic u,
                        input logic [AW-1:0] a, input logic [31:0] d);
    logic e; logic [31:0] r; int kind;
    model(w, s, u, a, d, e, r, kind);
    @(negedge clk);
    check("idle_rdy1", ready1, 1);
    check("idle_rdy4", ready4, 1);
    drive(w, s, u, a, d);
    req1 = 1'b1; req4 = 1'b1;
    @(posedge clk); #1;
    req1 = 1'b0; req4 = 1'b0;
    check("busy_rdy1", ready1, 0);
    check("busy_rdy4", ready4, 0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check("valid1", valid1, 32'(k == 1));
      check("valid4", valid4, 32'(k == 4));
      check("ready1", ready1, 1);
      check("ready4", ready4, 32'(k >= 4));
      if (k == 1) begin
        if (kind == 0) exp_rd1 = r;
        cnt1[kind]++;
      end
      if (k == 4) begin
        if (kind == 0) exp_rd4 = r;
        cnt4[kind]++;
      end
      check("err1", err1, (k == 1) ? 32'(e) : 32'd0);
      check("err4", err4, (k == 4) ? 32'(e) : 32'd0);
      check("rdata1", rdata1, exp_rd1);
      check("rdata4", rdata4, exp_rd4);
    end
    stats_check("acc");
  endtask

  // The LATENCY-4 instance keeps req high through BUSY with new fields on
  // the bus; the second request must be accepted in the response cycle and
  // must not be disturbed by field changes before that.
  task automatic held_test(input logic w, input logic [1:0] s, input logic u,
                           input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [1:0] s2, input logic u2, input logic [AW-1:0] a2);
    logic ea, eb; logic [31:0] ra, rb; int ka, kb;
    model(w, s, u, a, d, ea, ra, ka);
    model(1'b0, s2, u2, a2, 32'h0, eb, rb, kb);
    @(negedge clk);
    check("h_idle_rdy4", ready4, 1);
    drive(w, s, u, a, d);
    req1 = 1'b1; req4 = 1'b1;
    @(posedge clk); #1;
    req1 = 1'b0;
    drive(1'b0, s2, u2, a2, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 5) req4 = 1'b0;
      check("h_valid1", valid1, 32'(k == 1));
      check("h_valid4", valid4, 32'(k == 4 || k == 9));
      check("h_ready4", ready4, 32'(k == 4 || k >= 9));
      if (k == 1) begin
        if (ka == 0) exp_rd1 = ra;
        cnt1[ka]++;
      end
      if (k == 4) begin
        if (ka == 0) exp_rd4 = ra;
        cnt4[ka]++;
      end
      if (k == 9) begin
        if (kb == 0) exp_rd4 = rb;
        cnt4[kb]++;
      end
      check("h_err1", err1, (k == 1) ? 32'(ea) : 32'd0);
      check("h_err4", err4, (k == 4) ? 32'(ea) : (k == 9) ? 32'(eb) : 32'd0);
      check("h_rdata1", rdata1, exp_rd1);
      check("h_rdata4", rdata4, exp_rd4);
    end
    stats_check("held");
  endtask

  // Reset lands while both instances are busy with a write; the write must
  // be lost and no response may appear.
  task automatic reset_test();
    @(negedge clk);
    drive(1'b1, 2'd2, 1'b0, 16'h0020, 32'h12345678);
    req1 = 1'b1; req4 = 1'b1;
    @(posedge clk); #1;
    req1 = 1'b0; req4 = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("rst_valid1", valid1, 0);
      check("rst_valid4", valid4, 0);
      check("rst_ready1", ready1, 0);
      check("rst_ready4", ready4, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_rd1 = 32'h0; exp_rd4 = 32'h0;
    for (int i = 0; i < 3; i++) begin
      cnt1[i] = 0; cnt4[i] = 0;
    end
    check("rst_rdata1", rdata1, 0);
    check("rst_rdata4", rdata4, 0);
    stats_check("rst");
    access(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0);
  endtask

  initial begin
    logic          w;
    logic [1:0]    s;
    logic [1:0]    s2;
    logic [AW-1:0] a;
    logic [AW-1:0] a2;
    rst = 1'b1; req1 = 1'b0; req4 = 1'b0;
    drive(1'b0, 2'd0, 1'b0, '0, 32'h0);
    exp_rd1 = 32'h0; exp_rd4 = 32'h0;
    for (int i = 0; i < 3; i++) begin
      cnt1[i] = 0; cnt4[i] = 0;
    end
    #2;
    check("por_ready1", ready1, 0);
    check("por_ready4", ready4, 0);
    check("por_valid1", valid1, 0);
    check("por_err4",   err4,   0);
    check("por_rdata1", rdata1, 0);
    check("por_rdata4", rdata4, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stats_check("por");

    // Give every byte a known value
    for (int i = 0; i < DEPTH; i += 4) access(1'b1, 2'd2, 1'b0, AW'(i), $urandom);

    // Directed scenarios
    access(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF);
    access(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
    check("dir_word", rdata1, 32'hDEADBEEF);
    access(1'b0, 2'd0, 1'b0, 16'h0013, 32'h0);
    check("dir_sbyte", rdata4, 32'hFFFFFFDE);
    access(1'b0, 2'd0, 1'b1, 16'h0013, 32'h0);
    check("dir_ubyte", rdata4, 32'h000000DE);
    access(1'b0, 2'd1, 1'b0, 16'h0010, 32'h0);
    check("dir_shalf", rdata1, 32'hFFFFBEEF);
    access(1'b1, 2'd0, 1'b0, 16'h0011, 32'hFFFFFF55);
    access(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
    check("dir_partial", rdata1, 32'hDEAD55EF);
    access(1'b0, 2'd1, 1'b0, 16'h0011, 32'h0);
    access(1'b1, 2'd2, 1'b0, 16'h0012, 32'hCAFEF00D);
    access(1'b0, 2'd0, 1'b1, AW'(DEPTH), 32'h0);
    access(1'b1, 2'd0, 1'b0, AW'(DEPTH), 32'h000000AA);
    access(1'b1, 2'd3, 1'b0, 16'h0004, 32'h11111111);
    access(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
    check("dir_unchanged", rdata4, 32'hDEAD55EF);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      w = 1'($urandom);
      s = 2'($urandom);
      a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) != 0) a = a & ~AW'((1 << s) - 1);
      access(w, s, 1'($urandom), a, $urandom);
    end

    // Held request through BUSY on the slow instance
    for (int n = 0; n < 3; n++) begin
      s  = 2'($urandom_range(0, 2));
      s2 = 2'($urandom_range(0, 2));
      a  = AW'($urandom_range(0, DEPTH - 1)) & ~AW'((1 << s) - 1);
      a2 = AW'($urandom_range(0, DEPTH - 1)) & ~AW'((1 << s2) - 1);
      held_test(1'($urandom), s, 1'($urandom), a, $urandom, s2, 1'($urandom), a2);
    end

    reset_test();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
